// File: rtl/ddr_write_arbiter.sv
// Round-robin arbiter sharing one DDR write port between N_REQ show-ahead FIFOs.
// A winner holds the port for up to MAX_BURST beats; a stall watchdog flags a stuck DDR.
module ddr_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 4096
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [32*N_REQ-1:0]    req_addr,
  input  logic [32*N_REQ-1:0]    req_data,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       grant,
  output logic [31:0]            DDR_WRITE_ADDR,
  output logic [31:0]            DDR_WRITE_DATA,
  output logic                   DDR_WRITE_REQ,
  input  logic                   DDR_WRITE_READY,
  output logic                   stall_err,
  output logic [31:0]            beat_total,
  output logic [0:0]             dbg_state,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]         dbg_rr_ptr,
  output logic [((MAX_BURST > 1) ? $clog2(MAX_BURST) : 1)-1:0] dbg_beat_cnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int SC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic             stall_err_q, stall_err_d;
  logic [31:0]      beat_total_q, beat_total_d;

  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] next_ptr;
  logic             wr_req;
  logic             beat;
  logic             burst_end;
  logic             release_now;
  logic             stalling;

  // First requester at or after ptr, wrapping modulo N_REQ; ptr itself if none.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [PTR_W-1:0] ptr);
    logic found;
    int   idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && r[idx]) begin
        rr_pick = PTR_W'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    owner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) owner = PTR_W'(i);
    end
  end

  // Handshake: a beat transfers when DDR_WRITE_REQ && DDR_WRITE_READY in the same
  // cycle; the owner's ack pulses that cycle so its FIFO pops and shows the next word.
  always_comb begin
    wr_req         = (state_q == ST_GRANT) && req[owner];
    beat           = wr_req && DDR_WRITE_READY;
    stalling       = wr_req && !DDR_WRITE_READY;
    ack            = beat ? grant_q : '0;
    DDR_WRITE_ADDR = '0;
    DDR_WRITE_DATA = '0;
    if (state_q == ST_GRANT) begin
      DDR_WRITE_ADDR = req_addr[32*int'(owner) +: 32];
      DDR_WRITE_DATA = req_data[32*int'(owner) +: 32];
    end
    next_ptr    = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
    burst_end   = beat && (beat_cnt_q == BC_W'(MAX_BURST - 1));
    release_now = (state_q == ST_GRANT) && (!req[owner] || burst_end);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = N_REQ'(1) << rr_pick(req, rr_ptr_q);
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          // Handing over in the same cycle avoids an idle bubble between owners.
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
          if (|req) begin
            grant_d = N_REQ'(1) << rr_pick(req, next_ptr);
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + BC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = '0;
    if (stalling) begin
      stall_cnt_d = (stall_cnt_q == SC_W'(TIMEOUT - 1)) ? stall_cnt_q
                                                         : stall_cnt_q + SC_W'(1);
    end
    stall_err_d  = stall_err_q || (stalling && (stall_cnt_q == SC_W'(TIMEOUT - 1)));
    beat_total_d = beat_total_q + 32'(beat);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      stall_err_q  <= 1'b0;
      beat_total_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_err_q  <= stall_err_d;
      beat_total_q <= beat_total_d;
    end
  end

  assign grant         = grant_q;
  assign DDR_WRITE_REQ = wr_req;
  assign stall_err     = stall_err_q;
  assign beat_total    = beat_total_q;
  assign dbg_state     = state_q;
  assign dbg_rr_ptr    = rr_ptr_q;
  assign dbg_beat_cnt  = beat_cnt_q;

  a_grant_onehot0: assert property (@(posedge sys_clk) disable iff (sys_rst)
    $onehot0(grant_q));
  a_ack_in_grant: assert property (@(posedge sys_clk) disable iff (sys_rst)
    (ack & ~grant_q) == '0);

endmodule

// File: tb/tb_ddr_write_arbiter.sv
// Bench for ddr_write_arbiter: directed scenarios plus random traffic, all checked
// against a behavioural owner/pointer model of the arbitration rules.
module tb_ddr_write_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_addr;
  logic [127:0] req_data;
  logic         ready;
  logic [3:0]   ack;
  logic [3:0]   grant;
  logic [31:0]  wa;
  logic [31:0]  wd;
  logic         wreq;
  logic         stall_err;
  logic [31:0]  beat_total;
  logic [0:0]   dbg_state;
  logic [1:0]   dbg_rr_ptr;
  logic [1:0]   dbg_beat_cnt;

  always #5 clk = ~clk;

  ddr_write_arbiter #(.N_REQ(N), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .sys_clk(clk), .sys_rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .grant(grant), .DDR_WRITE_ADDR(wa), .DDR_WRITE_DATA(wd),
    .DDR_WRITE_REQ(wreq), .DDR_WRITE_READY(ready), .stall_err(stall_err),
    .beat_total(beat_total), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr),
    .dbg_beat_cnt(dbg_beat_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the port, where the round-robin search starts,
  // beats in the current burst, length of the current stall run.
  int          m_owner;
  int          m_ptr;
  int          m_burst;
  int          m_run;
  logic        m_err;
  logic [31:0] m_total;
  logic [31:0] exp_q[$];
  logic [72:0] exp_vec;
  logic [37:0] exp_st;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_burst = 0; m_run = 0; m_err = 1'b0; m_total = '0;
    exp_q.delete();
  endtask

  task automatic model_expect();
    logic [3:0]  g;
    logic        drq;
    logic [31:0] a;
    logic [31:0] d;
    g = '0; drq = 1'b0; a = '0; d = '0;
    if (m_owner >= 0) begin
      g   = 4'(1 << m_owner);
      drq = req[m_owner];
      a   = req_addr[32*m_owner +: 32];
      d   = req_data[32*m_owner +: 32];
    end
    exp_vec = {g, (drq && ready) ? g : 4'd0, drq, a, d};
    exp_st  = {m_total, m_err, (m_owner >= 0) ? 1'b1 : 1'b0, 2'(m_ptr), 2'(m_burst)};
  endtask

  task automatic model_advance();
    logic drq;
    logic beat;
    logic done;
    if (rst) begin
      model_reset();
      return;
    end
    drq  = (m_owner >= 0) && req[m_owner];
    beat = drq && ready;
    m_run = (drq && !ready) ? m_run + 1 : 0;
    if (m_run >= TO) m_err = 1'b1;
    if (beat) begin
      m_total = m_total + 1;
      exp_q.push_back(req_data[32*m_owner +: 32]);
    end
    if (m_owner < 0) begin
      if (req != 0) m_owner = pick(req, m_ptr);
    end else begin
      done = !req[m_owner] || (beat && m_burst == MB - 1);
      if (beat) m_burst = m_burst + 1;
      if (done) begin
        m_ptr   = (m_owner + 1) % N;
        m_burst = 0;
        m_owner = pick(req, m_ptr);
      end
    end
  endtask

  task automatic randomize_bus();
    for (int i = 0; i < N; i++) begin
      req_addr[32*i +: 32] = $urandom;
      req_data[32*i +: 32] = $urandom;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; ready = 1'b1;
    randomize_bus();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; req = '0;
    model_reset();
    #2;
    n_checks++;
    if ({grant, ack, wreq} !== 9'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", {grant, ack, wreq});
    end
    n_checks++;
    if ({beat_total, stall_err} !== 33'd0) begin
      n_fail++; $display("FAIL reset_counters: got %h required 0", {beat_total, stall_err});
    end
    n_checks++;
    if ({dbg_state, dbg_rr_ptr, dbg_beat_cnt} !== 5'd0) begin
      n_fail++; $display("FAIL reset_state: got %h required 0", {dbg_state, dbg_rr_ptr, dbg_beat_cnt});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0001; ready = 1'b1;
    randomize_bus();
    for (int c = 0; c < 13; c++) begin
      #2; model_expect();
      n_checks++;
      if ({grant, ack, wreq, wa, wd} !== exp_vec) begin
        n_fail++; $display("FAIL single_bus c%0d: got %h required %h", c, {grant, ack, wreq, wa, wd}, exp_vec);
      end
      n_checks++;
      if ({beat_total, stall_err, dbg_state, dbg_rr_ptr, dbg_beat_cnt} !== exp_st) begin
        n_fail++; $display("FAIL single_state c%0d: got %h required %h", c, {beat_total, stall_err, dbg_state, dbg_rr_ptr, dbg_beat_cnt}, exp_st);
      end
      if (c >= 1) begin
        n_checks++;
        if (grant !== 4'b0001 || ack !== 4'b0001) begin
          n_fail++; $display("FAIL single_grant c%0d: got grant %b ack %b required 0001", c, grant, ack);
        end
      end
      model_advance(); @(posedge clk); #1;
    end
    n_checks++;
    if (beat_total !== 32'd12) begin
      n_fail++; $display("FAIL single_total: got %0d required 12", beat_total);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] want;
    apply_reset();
    req = 4'b1111; ready = 1'b1;
    randomize_bus();
    for (int c = 0; c < 17; c++) begin
      #2; model_expect();
      n_checks++;
      if ({grant, ack, wreq, wa, wd} !== exp_vec) begin
        n_fail++; $display("FAIL fair_bus c%0d: got %h required %h", c, {grant, ack, wreq, wa, wd}, exp_vec);
      end
      n_checks++;
      if ({beat_total, stall_err, dbg_state, dbg_rr_ptr, dbg_beat_cnt} !== exp_st) begin
        n_fail++; $display("FAIL fair_state c%0d: got %h required %h", c, {beat_total, stall_err, dbg_state, dbg_rr_ptr, dbg_beat_cnt}, exp_st);
      end
      if (c >= 1) begin
        want = 4'(1 << ((c - 1) / MB));
        n_checks++;
        if (grant !== want || ack !== want) begin
          n_fail++; $display("FAIL fair_seq c%0d: got grant %b ack %b required %b", c, grant, ack, want);
        end
      end
      model_advance(); @(posedge clk); #1;
    end
    n_checks++;
    if (beat_total !== 32'd16) begin
      n_fail++; $display("FAIL fair_total: got %0d required 16", beat_total);
    end
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    req = 4'b0010; ready = 1'b1;
    randomize_bus();
    for (int c = 0; c < 5; c++) begin
      if (c >= 1) ready = pat[c-1];
      #2; model_expect();
      n_checks++;
      if ({grant, ack, wreq, wa, wd} !== exp_vec) begin
        n_fail++; $display("FAIL bp_bus c%0d: got %h required %h", c, {grant, ack, wreq, wa, wd}, exp_vec);
      end
      if (c >= 1) begin
        n_checks++;
        if (ack !== {2'b00, ready, 1'b0} || wa !== req_addr[63:32] || wd !== req_data[63:32]) begin
          n_fail++; $display("FAIL bp_hold c%0d: got ack %b addr %h data %h", c, ack, wa, wd);
        end
      end
      model_advance(); @(posedge clk); #1;
    end
    n_checks++;
    if (dbg_beat_cnt !== 2'd2 || grant !== 4'b0010) begin
      n_fail++; $display("FAIL bp_count: got beat_cnt %0d grant %b required 2 0010", dbg_beat_cnt, grant);
    end
  endtask

  task automatic test_early_drop();
    apply_reset();
    req = 4'b1100; ready = 1'b1;
    randomize_bus();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) req = 4'b1000;
      #2; model_expect();
      n_checks++;
      if ({grant, ack, wreq, wa, wd} !== exp_vec) begin
        n_fail++; $display("FAIL drop_bus c%0d: got %h required %h", c, {grant, ack, wreq, wa, wd}, exp_vec);
      end
      model_advance(); @(posedge clk); #1;
    end
    n_checks++;
    if (grant !== 4'b1000 || dbg_rr_ptr !== 2'd3 || beat_total !== 32'd2) begin
      n_fail++; $display("FAIL drop_handover: got grant %b ptr %0d total %0d required 1000 3 2", grant, dbg_rr_ptr, beat_total);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    req = 4'b0001; ready = 1'b0;
    randomize_bus();
    for (int c = 0; c < 22; c++) begin
      if (c == 17) ready = 1'b1;
      #2; model_expect();
      n_checks++;
      if ({beat_total, stall_err, dbg_state, dbg_rr_ptr, dbg_beat_cnt} !== exp_st) begin
        n_fail++; $display("FAIL stall_state c%0d: got %h required %h", c, {beat_total, stall_err, dbg_state, dbg_rr_ptr, dbg_beat_cnt}, exp_st);
      end
      model_advance(); @(posedge clk); #1;
      if (c == 15) begin
        n_checks++;
        if (stall_err !== 1'b0) begin
          n_fail++; $display("FAIL stall_early: got %b required 0 after 15 stalls", stall_err);
        end
      end
      if (c == 16 || c == 21) begin
        n_checks++;
        if (stall_err !== 1'b1) begin
          n_fail++; $display("FAIL stall_flag c%0d: got %b required 1", c, stall_err);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req = 4'b0001; ready = 1'b0;
    randomize_bus();
    for (int c = 0; c < 20; c++) begin
      if (c == 17) ready = 1'b1;
      if (c == 19) rst = 1'b1;
      #2; model_expect();
      n_checks++;
      if ({grant, ack, wreq, wa, wd} !== exp_vec) begin
        n_fail++; $display("FAIL rstmid_bus c%0d: got %h required %h", c, {grant, ack, wreq, wa, wd}, exp_vec);
      end
      model_advance(); @(posedge clk); #1;
    end
    rst = 1'b0;
    #2;
    n_checks++;
    if (grant !== 4'd0 || wreq !== 1'b0 || ack !== 4'd0 || beat_total !== 32'd0 || stall_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: got grant %b req %b ack %b total %0d err %b", grant, wreq, ack, beat_total, stall_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      ready = ($urandom_range(0, 3) != 0);
      randomize_bus();
      #2; model_expect();
      n_checks++;
      if ({grant, ack, wreq, wa, wd} !== exp_vec) begin
        n_fail++; $display("FAIL rand_bus c%0d: got %h required %h", c, {grant, ack, wreq, wa, wd}, exp_vec);
      end
      n_checks++;
      if ({beat_total, stall_err, dbg_state, dbg_rr_ptr, dbg_beat_cnt} !== exp_st) begin
        n_fail++; $display("FAIL rand_state c%0d: got %h required %h", c, {beat_total, stall_err, dbg_state, dbg_rr_ptr, dbg_beat_cnt}, exp_st);
      end
      model_advance();
      if (ack != 0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_sb c%0d: got beat %h required no beat", c, wd);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (wd !== e) begin
            n_fail++; $display("FAIL rand_sb c%0d: got %h required %h", c, wd, e);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_sb_drain: got %0d unmatched beats required 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; ready = 1'b0; req_addr = '0; req_data = '0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_early_drop();
    test_stall();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_write_arbiter.md
Name: ddr_write_arbiter

Overview:
- Shares the single DDR write port between up to N_REQ show-ahead FIFO requesters: camera frame writer, optical-flow result writer, pedestrian-bbox overlay writer, and one spare.
- Round-robin arbitration with a burst lock: a winner keeps the port for up to MAX_BURST beats, then must re-arbitrate.
- Sits between the requester FIFOs and the DDR_WRITE_* interface.
- Drives each requester's FIFO rdreq through a per-requester ack.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 64, maximum consecutive beats per grant (1..1024).
- TIMEOUT, 4096, cycles of request-without-ready before the stall flag sets.

Ports:
- sys_clk  in  1  single clock for all logic; the DDR write clock domain.
- sys_rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester request (FIFO !rdempty).
- req_addr  in  32*N_REQ  flattened addresses; requester i occupies [32i+31:32i].
- req_data  in  32*N_REQ  flattened data, same packing as req_addr.
- ack  out  N_REQ  one-hot beat-accepted strobe; feeds the requester FIFO rdreq.
- grant  out  N_REQ  one-hot current owner; 0 when idle.
- DDR_WRITE_ADDR  out  32  address of the granted requester.
- DDR_WRITE_DATA  out  32  data of the granted requester.
- DDR_WRITE_REQ  out  1  write request.
- DDR_WRITE_READY  in  1  DDR accepts the beat this cycle.
- stall_err  out  1  sticky flag: DDR_WRITE_READY stayed low for TIMEOUT cycles while DDR_WRITE_REQ=1.
- beat_total  out  32  free-running count of accepted beats; wraps.

Behaviour:
- Reset values: state=IDLE, grant=0, ack=0, DDR_WRITE_REQ=0, rr_ptr=0, beat_cnt=0, stall_cnt=0, stall_err=0, beat_total=0.
- Round-robin winner: the first i with req[i]=1, searched from rr_ptr upward modulo N_REQ.
- IDLE state:
  - If req≠0, register the winner into grant and go to GRANT.
  - Otherwise stay in IDLE.
  - Latency from a req rising edge to DDR_WRITE_REQ is 1 cycle.
- GRANT state, owner g:
  - DDR_WRITE_REQ = req[g] (combinational).
  - DDR_WRITE_ADDR and DDR_WRITE_DATA = slice g, combinational show-ahead.
  - Outside GRANT, ADDR and DATA are 0.
- Beat rule:
  - A beat occurs when DDR_WRITE_REQ && DDR_WRITE_READY.
  - ack[g] = beat, in the same cycle; all other ack bits are 0.
  - On a beat: beat_cnt++ and beat_total++.
- Release condition, evaluated each GRANT cycle:
  - (a) req[g]=0, or
  - (b) a beat occurs with beat_cnt==MAX_BURST-1.
- On release:
  - rr_ptr = (g+1) mod N_REQ; beat_cnt=0.
  - The next winner is computed from the current req vector using the new rr_ptr.
  - Any req → GRANT with the new winner next cycle (no bubble). Otherwise → IDLE and grant=0.
  - The owner g may win again only when no other requester is asserting.
- Requester dropping req without a beat (protocol violation): release per (a); no beat is counted.
- Stall watchdog:
  - stall_cnt increments while DDR_WRITE_REQ=1 && DDR_WRITE_READY=0; it clears on any beat or when DDR_WRITE_REQ=0.
  - stall_err sets when stall_cnt reaches TIMEOUT-1 and clears only on reset.
  - Arbitration is unaffected by stall_err.
- Grant changes occur only at release; the grant never switches mid-beat while DDR_WRITE_READY is low.
- Reset asserted mid-burst: all state returns to reset values on the next edge. DDR_WRITE_REQ and ack are 0 in the cycle after reset is sampled; partial bursts are abandoned.
- Widths: beat_cnt is clog2(MAX_BURST) bits, stall_cnt is clog2(TIMEOUT) bits, beat_total wraps 0xFFFFFFFF→0.

Test Plan:
- Single requester: req[0]=1 constantly, READY=1, MAX_BURST=4. Required: grant=0001 from cycle 1; ack[0] high every cycle; grant stays 0001 across the cap (re-win, no bubble); beat_total=12 after 12 beats.
- Fairness: req=1111 constantly, READY=1, MAX_BURST=4. Required: grant sequence 0001,0010,0100,1000 with 4 beats each; no idle cycles; beat_total=16 after 16 cycles from the first grant.
- Backpressure: owner 1, READY toggling 1,0,0,1. Required: ack[1] only in READY=1 cycles; ADDR and DATA hold slice 1 throughout; beat_cnt advances 2 over 4 cycles.
- Early drop: req[2] drops after 2 beats with req[3]=1. Required: grant=1000 on the next cycle; rr_ptr=3.
- Stall: req[0]=1, READY=0 for TIMEOUT=16 cycles. Required: stall_err=1 at cycle 16 and stays 1 after READY returns.
- Reset mid-burst: sys_rst=1 at beat 2 of 4. Required: next cycle grant=0, DDR_WRITE_REQ=0, beat_total=0, stall_err=0.
